line_buf_multi: RTL and testbench

- Multi-row line buffer for 2D window filters (3x3 / 5x5 dark-channel, guided filter) in the dehaze pipeline.
- Accepts a raster pixel stream with gaps and outputs a vertical column of NUM_LINES+1 vertically aligned pixels per accepted pixel.
- Also outputs the column's x/y coordinates, end-of-line flag and a row-validity mask.
- Line width is runtime-programmable up to MAX_WIDTH and latched at start of frame.

---
 rtl/line_buf_multi.sv | 147 ++++++++++++++
 tb/tb_line_buf_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_multi.sv
// Multi-row line buffer: emits a vertical column of NUM_LINES+1 aligned
// pixels, plus coordinates, end-of-line and row-validity, per input pixel.
module line_buf_multi #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_LINES    = 2,
  parameter int MAX_WIDTH    = 640,
  parameter int ZERO_INVALID = 1,
  parameter int Y_WIDTH      = 11,
  localparam int XW = $clog2(MAX_WIDTH + 1),
  localparam int CW = (NUM_LINES + 1) * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XW-1:0]         cfg_width,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [CW-1:0]         out_col,
  output logic [XW-1:0]         out_x,
  output logic [Y_WIDTH-1:0]    out_y,
  output logic                  out_eol,
  output logic [NUM_LINES-1:0]  out_rows_valid
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [XW-1:0] WMAX = XW'(MAX_WIDTH);

  logic [XW-1:0]        x_q;
  logic [XW-1:0]        w_q;
  logic [Y_WIDTH-1:0]   y_q;
  logic [WS-1:0]        wsel_q;
  logic [NUM_LINES-1:0] rv_q;

  logic [XW-1:0]        cx;
  logic [XW-1:0]        cw;
  logic [Y_WIDTH-1:0]   cy;
  logic [WS-1:0]        cws;
  logic [NUM_LINES-1:0] crv;
  logic                 eol;
  logic [AW-1:0]        addr;

  logic [DATA_WIDTH-1:0] mem [NUM_LINES][MAX_WIDTH];
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] tap0_q;
  logic [WS-1:0]         osel_q;

  // A start-of-frame pixel is processed as the origin of a fresh frame.
  always_comb begin
    cx  = x_q;
    cy  = y_q;
    cws = wsel_q;
    crv = rv_q;
    cw  = w_q;
    if (in_sof) begin
      cx  = '0;
      cy  = '0;
      cws = '0;
      crv = '0;
      if (cfg_width == '0 || cfg_width > WMAX)
        cw = WMAX;
      else
        cw = cfg_width;
    end
  end

  assign eol  = (cx == cw - XW'(1));
  assign addr = cx[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      y_q            <= '0;
      wsel_q         <= '0;
      rv_q           <= '0;
      w_q            <= WMAX;
      out_valid      <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
      out_eol        <= 1'b0;
      out_rows_valid <= '0;
      tap0_q         <= '0;
      osel_q         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_x          <= cx;
        out_y          <= cy;
        out_eol        <= eol;
        out_rows_valid <= crv;
        tap0_q         <= in_data;
        osel_q         <= cws;
        w_q            <= cw;
        if (eol) begin
          x_q    <= '0;
          y_q    <= (&cy) ? cy : cy + Y_WIDTH'(1);
          wsel_q <= (cws == WS'(NUM_LINES - 1)) ? '0 : cws + WS'(1);
          rv_q   <= NUM_LINES'({crv, 1'b1});
        end else begin
          x_q    <= cx + XW'(1);
          y_q    <= cy;
          wsel_q <= cws;
          rv_q   <= crv;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && !rst)
      mem[cws][addr] <= in_data;
  end

  // Registered read returns the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < NUM_LINES; i++)
        rd_q[i] <= mem[i][addr];
    end
  end

  int                    src;
  logic [DATA_WIDTH-1:0] tap;

  always_comb begin
    out_col = '0;
    src     = 0;
    tap     = '0;
    out_col[0 +: DATA_WIDTH] = tap0_q;
    for (int k = 1; k <= NUM_LINES; k++) begin
      src = int'(osel_q) - k;
      if (src < 0)
        src = src + NUM_LINES;
      tap = '0;
      for (int i = 0; i < NUM_LINES; i++)
        if (i == src)
          tap = rd_q[i];
      if (ZERO_INVALID != 0 && !out_rows_valid[k-1])
        tap = '0;
      out_col[k*DATA_WIDTH +: DATA_WIDTH] = tap;
    end
  end

endmodule

// File: tb/tb_line_buf_multi.sv
// Directed bench for line_buf_multi with an image-history reference model
// and a scoreboard queue of expected output columns.
module tb_line_buf_multi;

  localparam int DW = 8;
  localparam int NL = 2;
  localparam int MW = 8;
  localparam int XW = $clog2(MW + 1);
  localparam int YW = 11;
  localparam int CW = (NL + 1) * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XW-1:0] cfg_width = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_eol;
  logic [NL-1:0] out_rows_valid;

  line_buf_multi #(
    .DATA_WIDTH(DW),
    .NUM_LINES(NL),
    .MAX_WIDTH(MW),
    .ZERO_INVALID(1),
    .Y_WIDTH(YW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_width(cfg_width),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_col(out_col),
    .out_x(out_x),
    .out_y(out_y),
    .out_eol(out_eol),
    .out_rows_valid(out_rows_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          eol;
    logic [NL-1:0] rv;
  } exp_t;

  exp_t sb[$];
  exp_t last = '0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int            fx = 0;
  int            fy = 0;
  int            fw = MW;
  logic [DW-1:0] img [64][MW];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int eff(input int c);
    return (c == 0 || c > MW) ? MW : c;
  endfunction

  task automatic check_outs();
    chk("col", 32'(out_col), 32'(last.col));
    chk("x", 32'(out_x), 32'(last.x));
    chk("y", 32'(out_y), 32'(last.y));
    chk("eol", 32'(out_eol), 32'(last.eol));
    chk("rows_valid", 32'(out_rows_valid), 32'(last.rv));
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    exp_t e;
    logic [DW-1:0] t1, t2;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    if (v) begin
      if (s) begin
        fx = 0;
        fy = 0;
        fw = eff(int'(cfg_width));
      end
      t1 = (fy >= 1) ? img[(fy - 1) % 64][fx] : '0;
      t2 = (fy >= 2) ? img[(fy - 2) % 64][fx] : '0;
      e.col = {t2, t1, d};
      e.x   = XW'(fx);
      e.y   = YW'(fy);
      e.eol = (fx == fw - 1);
      e.rv  = {fy >= 2, fy >= 1};
      img[fy % 64][fx] = d;
      sb.push_back(e);
      if (fx == fw - 1) begin
        fx = 0;
        fy++;
      end else begin
        fx++;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(out_valid), 32'(v));
    if (v) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_underflow: got empty want entry");
      end else begin
        last = sb.pop_front();
      end
    end
    check_outs();
  endtask

  task automatic rst_step();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_data  = 8'hAA;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    fx = 0;
    fy = 0;
    fw = MW;
    sb.delete();
    last = '0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    check_outs();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    check_outs();
    @(negedge clk);
    rst = 1'b0;

    // Frame A: W=4, back-to-back 1..12.
    cfg_width = 4'd4;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, i == 1, DW'(i));
      if (i == 9)
        chk("p9_col", 32'(out_col), 32'h00010509);
      if (i == 4 || i == 8 || i == 12)
        chk("eol_pix", 32'(out_eol), 32'd1);
    end

    // Same stream with gaps; row 0 taps must stay masked.
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, i == 1, DW'(i));
      if (i == 2)
        chk("stale_mask", 32'(out_col[CW-1:DW]), 32'd0);
      step(1'b0, 1'b0, 8'hEE);
    end

    // Restart a frame mid-row (row 1, x=2).
    for (int i = 0; i < 6; i++)
      step(1'b1, i == 0, DW'(8'h30 + i));
    step(1'b1, 1'b1, 8'h40);
    chk("sof_mid_x", 32'(out_x), 32'd0);
    chk("sof_mid_rv", 32'(out_rows_valid), 32'd0);
    for (int i = 1; i < 8; i++)
      step(1'b1, 1'b0, DW'(8'h40 + i));

    // Out-of-range widths fall back to MAX_WIDTH.
    cfg_width = 4'd0;
    for (int i = 0; i < 16; i++)
      step(1'b1, i == 0, DW'(8'h50 + i));
    cfg_width = 4'd9;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, DW'(8'h70 + i));
      if (i == 7)
        chk("w9_eol", 32'(out_eol), 32'd1);
    end

    // Single-pixel rows.
    cfg_width = 4'd1;
    for (int i = 0; i < 6; i++)
      step(1'b1, i == 0, DW'(8'h90 + i));
    chk("w1_col", 32'(out_col), 32'h00939495);

    // Reset mid-row 1, then pixels without sof.
    cfg_width = 4'd4;
    for (int i = 0; i < 6; i++)
      step(1'b1, i == 0, DW'(8'hA0 + i));
    rst_step();
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, DW'(8'hC0 + i));

    @(negedge clk);
    in_valid = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
